// File: rtl/dec_pkg.sv
// Shared widths and the one-hot decode function for the 3-to-8 select decoder.
package dec_pkg;

    localparam int SEL_W = 3;
    localparam int OUT_W = 1 << SEL_W;

    // Written as mask-and-shift so an X on en or sel shows up as X on the result.
    function automatic logic [OUT_W-1:0] onehot(input logic en, input logic [SEL_W-1:0] sel);
        onehot = {OUT_W{en}} & (OUT_W'(1) << sel);
    endfunction

endpackage

// File: rtl/dec3_to_8_core.sv
// Pure combinational decode of (enable, select) into a one-hot output word.
module dec3_to_8_core
    import dec_pkg::*;
(
    input  logic             i_en,
    input  logic [SEL_W-1:0] i_a,
    output logic [OUT_W-1:0] o_y
);

    logic [OUT_W-1:0] w_dec;

    assign w_dec = onehot(i_en, i_a);

    genvar gi;
    generate
        for (gi = 0; gi < OUT_W; gi++) begin : g_bit
            assign o_y[gi] = w_dec[gi];
        end
    endgenerate

endmodule

// File: rtl/dec3_to_8.sv
// 3-to-8 one-hot decoder with enable; REG_OUT=1 adds one async-reset output register stage.
module dec3_to_8
    import dec_pkg::*;
#(
    parameter bit REG_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [SEL_W-1:0] a,
    output logic [OUT_W-1:0] y
);

    logic [OUT_W-1:0] w_dec;

    dec3_to_8_core u_core (
        .i_en (en),
        .i_a  (a),
        .o_y  (w_dec)
    );

    generate
        if (REG_OUT) begin : g_reg
            logic [OUT_W-1:0] r_y;

            // Reset clears the pending value so no stale select line survives it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_y <= '0;
                end else begin
                    r_y <= w_dec;
                end
            end

            assign y = r_y;

`ifndef SYNTHESIS
            chk_en_reg: assert property (@(posedge clk) disable iff (!rst_n)
                !$past(en) |-> (y == '0));
            chk_rst: assert property (@(negedge clk) !rst_n |-> (y == '0));
`endif
        end else begin : g_comb
            assign y = w_dec;

`ifndef SYNTHESIS
            chk_en_comb: assert property (@(posedge clk) disable iff (!rst_n)
                !en |-> (y == '0));
`endif
        end
    endgenerate

`ifndef SYNTHESIS
    chk_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(y));
`endif

endmodule

// File: tb/tb_dec3_to_8.sv
// Exercises the combinational and registered builds side by side with shared stimulus.
module tb_dec3_to_8;

    typedef struct {
        logic       en;
        logic [2:0] a;
        logic [7:0] y;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] a;
    logic [7:0] y0;
    logic [7:0] y1;

    int n_err;
    int n_chk;

    dec3_to_8 #(.REG_OUT(1'b0)) dut_comb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .a     (a),
        .y     (y0)
    );

    dec3_to_8 #(.REG_OUT(1'b1)) dut_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .a     (a),
        .y     (y1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the selected line carries weight 2**a when enabled, nothing otherwise.
    function automatic logic [7:0] ref_dec(input bit e, input int idx);
        int v;
        v = e ? (2 ** idx) : 0;
        return 8'(v);
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    vec_t       tbl[19];
    logic [7:0] sweep[8];
    logic [7:0] prev;
    logic [7:0] exp_v;
    bit         r_en;
    int         r_a;

    initial begin
        n_err = 0;
        n_chk = 0;

        sweep = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        for (int i = 0; i < 8; i++) tbl[i]     = '{1'b0, 3'(i), 8'h00};
        for (int i = 0; i < 8; i++) tbl[8 + i] = '{1'b1, 3'(i), sweep[i]};
        tbl[16] = '{1'b1, 3'b101, 8'h20};
        tbl[17] = '{1'b0, 3'b101, 8'h00};
        tbl[18] = '{1'b1, 3'b101, 8'h20};

        // Reset phase: registered output held low, combinational path unaffected.
        rst_n = 1'b0;
        en    = 1'b0;
        a     = 3'd0;
        #1;
        check("reset_reg", y1, 8'h00);
        check("reset_comb", y0, 8'h00);
        @(negedge clk);
        en = 1'b1;
        a  = 3'd3;
        @(posedge clk);
        #1;
        check("reset_reg_hold", y1, 8'h00);
        check("reset_comb_live", y0, 8'h08);
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_reg", y1, 8'h00);
        prev = 8'h00;

        // Disabled sweep, enabled sweep, enable toggle.
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            en = tbl[i].en;
            a  = tbl[i].a;
            #1;
            check("vec_comb", y0, tbl[i].y);
            check("vec_reg_hold", y1, prev);
            @(posedge clk);
            #1;
            check("vec_reg", y1, tbl[i].y);
            $display("vec %0d en=%0d a=%0d y_comb=%h y_reg=%h exp=%h",
                     i, tbl[i].en, tbl[i].a, y0, y1, tbl[i].y);
            prev = tbl[i].y;
        end

        // Asynchronous reset between edges, then release.
        @(negedge clk);
        en = 1'b1;
        a  = 3'd7;
        @(posedge clk);
        #1;
        check("async_pre", y1, 8'h80);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_drop", y1, 8'h00);
        check("async_comb", y0, 8'h80);
        $display("async reset asserted: y_reg=%h", y1);
        @(posedge clk);
        #1;
        check("async_hold", y1, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("async_release_wait", y1, 8'h00);
        @(posedge clk);
        #1;
        check("async_release_edge", y1, 8'h80);
        $display("async reset released: y_reg=%h", y1);
        prev = 8'h80;

        // Random stimulus against the reference model.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            r_en  = bit'($urandom_range(0, 1));
            r_a   = int'($urandom_range(0, 7));
            en    = r_en;
            a     = 3'(r_a);
            exp_v = ref_dec(r_en, r_a);
            #1;
            check("rand_comb", y0, exp_v);
            check("rand_reg_hold", y1, prev);
            @(posedge clk);
            #1;
            check("rand_reg", y1, exp_v);
            prev = exp_v;
        end
        $display("random: 1000 transactions applied");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
